fetch_unit: RTL and testbench

- Instruction-side front end that supplies `instr` to controlUnit and consumes its flow-control outputs: `branch`, `ret`, `loadPC`, plus a `call` strobe.
- Owns the program counter, a hardware return-address stack and the instruction register.
- Drives a synchronous-read instruction memory with 1-cycle read latency.
- Presents one instruction at a time and holds it until controlUnit retires it with `loadPC`.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, the return-address stack and the instruction register.
// It fetches from a memory with one cycle of read latency and holds each instruction until it is retired.
module fetch_unit #(
    parameter int ADDR_W      = 10,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               loadPC,
    input  logic               branch,
    input  logic               call,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc,
    output logic               stack_empty,
    output logic               stack_full,
    output logic               stack_err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, VALID, FAULT} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       pc_nxt;
    logic [SP_W-1:0]         sp, sp_nxt, sp_dec;
    logic                    err_nxt;
    logic                    push;
    logic [ADDR_W-1:0]       pc_inc;
    logic [ADDR_W-1:0]       stack [STACK_DEPTH];

    assign imem_addr = pc;
    assign pc_inc    = pc + ADDR_W'(1);
    assign sp_dec    = sp - SP_W'(1);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        err_nxt   = stack_err;
        push      = 1'b0;
        imem_en   = 1'b0;
        case (state)
            FETCH: begin
                imem_en   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  state_nxt = VALID;
            VALID: begin
                if (loadPC) begin
                    state_nxt = FETCH;
                    // ret outranks call, so call+ret pops without pushing
                    if (ret) begin
                        if (sp == '0) begin
                            err_nxt   = 1'b1;
                            state_nxt = FAULT;
                        end else begin
                            sp_nxt = sp_dec;
                            pc_nxt = stack[sp_dec[IDX_W-1:0]];
                        end
                    end else if (call) begin
                        if (sp == SP_MAX) begin
                            err_nxt   = 1'b1;
                            state_nxt = FAULT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                            pc_nxt = target;
                        end
                    end else if (branch) begin
                        pc_nxt = target;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            default: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= ADDR_W'(RESET_PC);
            instr       <= '0;
            instr_valid <= 1'b0;
            sp          <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            sp          <= sp_nxt;
            stack_err   <= err_nxt;
            stack_empty <= (sp_nxt == '0);
            stack_full  <= (sp_nxt == SP_MAX);
            if (state == WAIT) begin
                instr       <= imem_data;
                instr_valid <= 1'b1;
            end else if (state_nxt != VALID) begin
                instr_valid <= 1'b0;
            end
        end
    end

    // Stack storage carries no reset; sp alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and random retire sequences against a queue-based model
// of the PC and return stack, with instruction memory returning addr+0x100.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data = '0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        loadPC = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [9:0]  target = '0;
    logic [9:0]  pc;
    logic        stack_empty, stack_full, stack_err;

    int tests = 0;
    int fails = 0;

    logic [9:0] m_pc;
    logic [9:0] m_stack[$];
    logic       m_err;
    logic       m_fault;

    fetch_unit #(.ADDR_W(10), .INSTR_W(16), .STACK_DEPTH(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .loadPC(loadPC), .branch(branch), .call(call), .ret(ret), .target(target),
        .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (imem_en) imem_data <= {6'b0, imem_addr} + 16'h0100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({tag, ".full"}, 32'(stack_full), 32'(m_stack.size() == 8));
        chk({tag, ".err"}, 32'(stack_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_pc = '0; m_stack.delete(); m_err = 1'b0; m_fault = 1'b0;
        chk_flags("rst");
        chk("rst.instr", 32'(instr), 32'h0);
        chk("rst.valid", 32'(instr_valid), 32'h0);
        chk("rst.imem_en", 32'(imem_en), 32'h1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd2);
        chk({tag, ".instr"}, 32'(instr), 32'({6'b0, m_pc} + 16'h0100));
        chk({tag, ".imem_en"}, 32'(imem_en), 32'h0);
        chk_flags(tag);
    endtask

    task automatic retire(input string tag, input logic b, input logic c, input logic r,
                          input logic [9:0] t);
        loadPC = 1'b1; branch = b; call = c; ret = r; target = t;
        @(posedge clk); #1;
        loadPC = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        if (r) begin
            if (m_stack.size() == 0) begin m_err = 1'b1; m_fault = 1'b1; end
            else m_pc = m_stack.pop_back();
        end else if (c) begin
            if (m_stack.size() == 8) begin m_err = 1'b1; m_fault = 1'b1; end
            else begin
                m_stack.push_back(10'((int'(m_pc) + 1) % 1024));
                m_pc = t;
            end
        end else if (b) begin
            m_pc = t;
        end else begin
            m_pc = 10'((int'(m_pc) + 1) % 1024);
        end
        chk({tag, ".valid_drop"}, 32'(instr_valid), 32'h0);
        chk_flags(tag);
        if (m_fault) begin
            repeat (4) begin
                @(posedge clk); #1;
                chk({tag, ".fault_valid"}, 32'(instr_valid), 32'h0);
                chk({tag, ".fault_en"}, 32'(imem_en), 32'h0);
            end
            chk_flags({tag, ".fault"});
        end else begin
            wait_valid(tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and sequential fetches 0..5
        do_reset();
        wait_valid("first");
        for (int i = 0; i < 5; i++) retire("seq", 1'b0, 1'b0, 1'b0, '0);

        // Hold in VALID with loadPC low
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold.valid", 32'(instr_valid), 32'h1);
            chk("hold.instr", 32'(instr), 32'h0105);
            chk("hold.pc", 32'(pc), 32'h5);
            chk("hold.en", 32'(imem_en), 32'h0);
        end

        // Call/return pair
        retire("call40", 1'b0, 1'b1, 1'b0, 10'h040);
        retire("ret6", 1'b0, 1'b0, 1'b1, '0);
        chk("ret6.pc_abs", 32'(pc), 32'h6);

        // Overflow: 8 nested calls then a 9th
        for (int i = 0; i < 8; i++) retire("nest", 1'b0, 1'b1, 1'b0, 10'($urandom_range(0, 1023)));
        chk("nest.full", 32'(stack_full), 32'h1);
        retire("ovf", 1'b0, 1'b1, 1'b0, 10'h123);
        chk("ovf.err", 32'(stack_err), 32'h1);
        do_reset();
        wait_valid("post_ovf");

        // Underflow
        retire("unf", 1'b0, 1'b0, 1'b1, '0);
        do_reset();
        wait_valid("post_unf");

        // call+ret+branch with two entries stacked pops only
        retire("c1", 1'b0, 1'b1, 1'b0, 10'h010);
        retire("c2", 1'b0, 1'b1, 1'b0, 10'h020);
        retire("crb", 1'b1, 1'b1, 1'b1, 10'h3AA);
        chk("crb.pc_abs", 32'(pc), 32'h011);
        chk("crb.depth", 32'(m_stack.size()), 32'd1);

        // PC wrap and wrapped return address
        retire("to3ff", 1'b1, 1'b0, 1'b0, 10'h3FF);
        retire("wrap", 1'b0, 1'b0, 1'b0, '0);
        chk("wrap.pc_abs", 32'(pc), 32'h000);
        retire("to3ff_b", 1'b1, 1'b0, 1'b0, 10'h3FF);
        retire("callwrap", 1'b0, 1'b1, 1'b0, 10'h055);
        retire("retwrap", 1'b0, 1'b0, 1'b1, '0);
        chk("retwrap.pc_abs", 32'(pc), 32'h000);

        // Reset asserted while in WAIT
        loadPC = 1'b1; @(posedge clk); #1; loadPC = 1'b0;
        @(posedge clk); #1;
        do_reset();
        wait_valid("post_wait_rst");

        // Random retires
        for (int i = 0; i < 60; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            retire("rand", r[0], r[1] & r[3], r[2] & ~r[3], 10'($urandom_range(0, 1023)));
            if (m_fault) begin
                do_reset();
                wait_valid("rand_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
